// File: rtl/noc_mcast_pkg.sv
// Purpose : shared port codes, splitter FSM states and mesh node-index helpers.
// Latency : n/a (types, constants and constant functions only).
// Backpr. : n/a.
// Node index convention: idx = x*YDIM + y, x = column, y = row.
package noc_mcast_pkg;

   localparam int NPORT = 5;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   function automatic int node_x(input int idx, input int ydim);
      return idx / ydim;
   endfunction

   function automatic int node_y(input int idx, input int ydim);
      return idx % ydim;
   endfunction

   // Output port for destination (x,y) seen from router (mx,my).
   // yx_order=0 resolves the column first, yx_order=1 resolves the row first.
   function automatic logic [2:0] route_port(input int x, input int y,
                                             input int mx, input int my,
                                             input bit yx_order);
      logic [2:0] p;
      p = PORT_LOCAL;
      if (yx_order) begin
         if (y > my)      p = PORT_NORTH;
         else if (y < my) p = PORT_SOUTH;
         else if (x > mx) p = PORT_EAST;
         else if (x < mx) p = PORT_WEST;
      end else begin
         if (x > mx)      p = PORT_EAST;
         else if (x < mx) p = PORT_WEST;
         else if (y > my) p = PORT_NORTH;
         else if (y < my) p = PORT_SOUTH;
      end
      return p;
   endfunction

endpackage

// File: rtl/mcast_port_part.sv
// Purpose : splits a destination bitmap into five disjoint per-port masks.
// Latency : combinational, 0 cycles.
// Backpr. : none; pure function of the bitmap.
// Ports   : bitmap (N-bit destination set) -> local/north/east/south/west_mask (N bits each).
// Config  : MCAST_YX_PART_EN selects YX partitioning; undefined gives XY.
module mcast_port_part
   import noc_mcast_pkg::*;
#(
   parameter int XDIM    = 4,
   parameter int YDIM    = 4,
   parameter int MY_XPOS = 0,
   parameter int MY_YPOS = 0
) (
   input  logic [XDIM*YDIM-1:0] bitmap,
   output logic [XDIM*YDIM-1:0] local_mask,
   output logic [XDIM*YDIM-1:0] north_mask,
   output logic [XDIM*YDIM-1:0] east_mask,
   output logic [XDIM*YDIM-1:0] south_mask,
   output logic [XDIM*YDIM-1:0] west_mask
);

   localparam int N = XDIM * YDIM;

`ifdef MCAST_YX_PART_EN
   localparam bit YX_ORDER = 1'b1;
`else
   localparam bit YX_ORDER = 1'b0;
`endif

   // Every node's port is fixed at elaboration, so each mask bit is just a
   // gated copy of the bitmap bit; exactly one mask owns each node.
   for (genvar i = 0; i < N; i++) begin : g_node
      localparam logic [2:0] PORT = route_port(node_x(i, YDIM), node_y(i, YDIM),
                                               MY_XPOS, MY_YPOS, YX_ORDER);
      assign local_mask[i] = bitmap[i] & (PORT == PORT_LOCAL);
      assign north_mask[i] = bitmap[i] & (PORT == PORT_NORTH);
      assign east_mask[i]  = bitmap[i] & (PORT == PORT_EAST);
      assign south_mask[i] = bitmap[i] & (PORT == PORT_SOUTH);
      assign west_mask[i]  = bitmap[i] & (PORT == PORT_WEST);
   end

endmodule

// File: rtl/mcast_split_dec.sv
// Purpose : accepts a unicast/multicast header and issues one request per non-empty output port.
// Latency : first request registered 1 cycle after header acceptance.
// Backpr. : out_ready low holds the current request; in_ready low until the last request is taken.
// Ports   : clk, rst (sync, active high); in_valid/in_ready/in_um_type/in_uni_dst/in_mult_dst header
//           input; out_valid/out_ready/out_port/out_doc/out_last request output; err_empty pulse.
// Config  : MCAST_YX_PART_EN (in mcast_port_part) switches partitioning from XY to YX order.
module mcast_split_dec
   import noc_mcast_pkg::*;
#(
   parameter int XDIM    = 4,
   parameter int YDIM    = 4,
   parameter int MY_XPOS = 0,
   parameter int MY_YPOS = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_um_type,
   input  logic [$clog2(XDIM*YDIM)-1:0]  in_uni_dst,
   input  logic [XDIM*YDIM-1:0]          in_mult_dst,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2:0]                    out_port,
   output logic [XDIM*YDIM-1:0]          out_doc,
   output logic                          out_last,
   output logic                          err_empty
);

   localparam int N = XDIM * YDIM;

   state_t                  state;
   logic [N-1:0]            uni_bitmap;
   logic [N-1:0]            bitmap;
   logic [NPORT-1:0][N-1:0] part;
   logic [NPORT-1:0][N-1:0] pend;
   logic [NPORT-1:0][N-1:0] src;
   logic [NPORT-1:0][N-1:0] rest;
   logic                    found;
   logic [2:0]              sel_port;
   logic [N-1:0]            sel_doc;

   // Out-of-range unicast destinations match no bit and yield an empty bitmap.
   always_comb begin
      uni_bitmap = '0;
      for (int i = 0; i < N; i++) begin
         uni_bitmap[i] = (int'(in_uni_dst) == i);
      end
   end

   assign bitmap = in_um_type ? in_mult_dst : uni_bitmap;

   mcast_port_part #(
      .XDIM    (XDIM),
      .YDIM    (YDIM),
      .MY_XPOS (MY_XPOS),
      .MY_YPOS (MY_YPOS)
   ) u_part (
      .bitmap     (bitmap),
      .local_mask (part[0]),
      .north_mask (part[1]),
      .east_mask  (part[2]),
      .south_mask (part[3]),
      .west_mask  (part[4])
   );

   // One picker serves both the first request (fresh masks in IDLE) and the
   // following ones (pending masks in ISSUE), so empty ports cost no cycle.
   always_comb begin
      src      = (state == IDLE) ? part : pend;
      found    = 1'b0;
      sel_port = PORT_LOCAL;
      sel_doc  = '0;
      rest     = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (!found && (|src[p])) begin
            found    = 1'b1;
            sel_port = 3'(p);
            sel_doc  = src[p];
         end else begin
            rest[p] = src[p];
         end
      end
   end

   assign in_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= '0;
         out_valid <= 1'b0;
         out_port  <= PORT_LOCAL;
         out_doc   <= '0;
         out_last  <= 1'b0;
         err_empty <= 1'b0;
      end else begin
         err_empty <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (found) begin
                     state     <= ISSUE;
                     out_valid <= 1'b1;
                     out_port  <= sel_port;
                     out_doc   <= sel_doc;
                     out_last  <= ~(|rest);
                     pend      <= rest;
                  end else begin
                     err_empty <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               // out_valid is always high in ISSUE, so out_ready alone completes the handshake.
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_port  <= PORT_LOCAL;
                     out_doc   <= '0;
                     out_last  <= 1'b0;
                     pend      <= '0;
                  end else begin
                     out_port  <= sel_port;
                     out_doc   <= sel_doc;
                     out_last  <= ~(|rest);
                     pend      <= rest;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
